// File: rtl/motoro3_gate_monitor.sv
// Receive-side checker for the six-line 3-phase gate bus: sector/direction/period decode plus latched faults.
// Optional dead-time checking is built when MON_DEADTIME_CHECK_EN is defined; otherwise faultDead is tied to 0.
module motoro3_gate_monitor #(
    parameter int          PW       = 20,
    parameter int unsigned TIMEOUT  = 20'd1000000,
    parameter int          DEAD_MIN = 4
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          aHP,
    input  logic          aLN,
    input  logic          bHP,
    input  logic          bLN,
    input  logic          cHP,
    input  logic          cLN,
    input  logic          clrFault,
    output logic [2:0]    sector,
    output logic          running,
    output logic          dirRev,
    output logic [PW-1:0] period,
    output logic          periodValid,
    output logic          faultShoot,
    output logic          faultSkip,
    output logic          faultDead,
    output logic          faultAny
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t        state, stateNext;
    logic [2:0]    hOn, lOn;            // bit 0 = A, 1 = B, 2 = C
    logic          patShoot, patOff, patValid;
    logic [2:0]    decSec;
    logic [2:0]    secPlus, secMinus;
    logic          stepFwd, stepRev, secChange, entry0, toHit;
    logic [2:0]    sectorNext;
    logic          dirRevNext, skipSet, deadSet;
    logic          shootNext, skipNext, deadNext;
    logic [TW-1:0] toCnt;
    logic [PW-1:0] pCnt;
    logic          haveRef;

    // Normalise to "switch on" sense at the input register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hOn <= '0;
            lOn <= '0;
        end else begin
            hOn <= {cHP, bHP, aHP};
            lOn <= ~{cLN, bLN, aLN};
        end
    end

    assign patShoot = |(hOn & lOn);
    assign patOff   = (hOn == 3'b000) && (lOn == 3'b000);

    always_comb begin
        patValid = 1'b1;
        decSec   = 3'd0;
        unique case ({hOn, lOn})
            6'b001_010: decSec = 3'd0;
            6'b001_100: decSec = 3'd1;
            6'b010_100: decSec = 3'd2;
            6'b010_001: decSec = 3'd3;
            6'b100_001: decSec = 3'd4;
            6'b100_010: decSec = 3'd5;
            default:    patValid = 1'b0;
        endcase
    end

    assign secPlus   = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    assign secMinus  = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
    assign stepFwd   = patValid && (decSec == secPlus);
    assign stepRev   = patValid && (decSec == secMinus);
    assign secChange = patValid && (decSec != sector);
    assign entry0    = patValid && (decSec == 3'd0) && ((state == IDLE) || (sector != 3'd0));
    assign toHit     = (state != IDLE) && !secChange && (toCnt >= TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        sectorNext = sector;
        dirRevNext = dirRev;
        skipSet    = 1'b0;
        if (patOff) begin
            stateNext = IDLE;
        end else if (patShoot) begin
            stateNext = state;
        end else if (!patValid) begin
            skipSet = 1'b1;
        end else begin
            sectorNext = decSec;
            unique case (state)
                IDLE: stateNext = ARMED;
                ARMED: begin
                    if (stepFwd) begin
                        stateNext  = RUN;
                        dirRevNext = 1'b0;
                    end else if (stepRev) begin
                        stateNext  = RUN;
                        dirRevNext = 1'b1;
                    end else if (secChange) begin
                        skipSet = 1'b1;
                    end
                end
                RUN: begin
                    // A single step either way is legal; it just sets the direction.
                    if (stepFwd)        dirRevNext = 1'b0;
                    else if (stepRev)   dirRevNext = 1'b1;
                    else if (secChange) begin
                        skipSet   = 1'b1;
                        stateNext = ARMED;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        if (toHit) stateNext = IDLE;
    end

    assign running = (state == RUN);

`ifdef MON_DEADTIME_CHECK_EN
    localparam int DW = $clog2(DEAD_MIN + 1);

    logic [2:0][DW-1:0] offCnt;
    logic [2:0]         prevH, prevL, lastH, lastL, deadHit;

    always_comb begin
        deadHit = '0;
        for (int i = 0; i < 3; i++) begin
            deadHit[i] = (((hOn[i] & ~prevH[i]) & lastL[i]) | ((lOn[i] & ~prevL[i]) & lastH[i]))
                         && (offCnt[i] < DW'(DEAD_MIN));
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            offCnt <= '0;
            prevH  <= '0;
            prevL  <= '0;
            lastH  <= '0;
            lastL  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                prevH[i] <= hOn[i];
                prevL[i] <= lOn[i];
                if (hOn[i] | lOn[i])                 offCnt[i] <= '0;
                else if (offCnt[i] != DW'(DEAD_MIN)) offCnt[i] <= offCnt[i] + 1'b1;
                // Remember which side conducted last; a shoot-through cycle leaves it unchanged.
                if (hOn[i] & ~lOn[i]) begin
                    lastH[i] <= 1'b1;
                    lastL[i] <= 1'b0;
                end else if (lOn[i] & ~hOn[i]) begin
                    lastH[i] <= 1'b0;
                    lastL[i] <= 1'b1;
                end
            end
        end
    end

    assign deadSet = |deadHit;
`else
    assign deadSet = 1'b0;
`endif

    assign shootNext = patShoot | (faultShoot & ~clrFault);
    assign skipNext  = skipSet  | (faultSkip  & ~clrFault);
    assign deadNext  = deadSet  | (faultDead  & ~clrFault);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sector      <= 3'd0;
            dirRev      <= 1'b0;
            toCnt       <= '0;
            pCnt        <= '0;
            haveRef     <= 1'b0;
            period      <= '0;
            periodValid <= 1'b0;
            faultShoot  <= 1'b0;
            faultSkip   <= 1'b0;
            faultDead   <= 1'b0;
            faultAny    <= 1'b0;
        end else begin
            sector      <= sectorNext;
            dirRev      <= dirRevNext;
            periodValid <= 1'b0;

            if ((state == IDLE) || (stateNext == IDLE) || secChange) toCnt <= '0;
            else if (toCnt != TW'(TIMEOUT))                          toCnt <= toCnt + 1'b1;

            // Period needs a reference sector-0 entry since IDLE before it can be measured.
            if ((stateNext == IDLE) || entry0) pCnt <= '0;
            else if ((state != IDLE) && (pCnt != '1)) pCnt <= pCnt + 1'b1;

            if (stateNext == IDLE) haveRef <= 1'b0;
            else if (entry0)       haveRef <= 1'b1;

            if (entry0 && (state == RUN) && haveRef) begin
                period      <= (pCnt == '1) ? pCnt : pCnt + 1'b1;
                periodValid <= 1'b1;
            end

            faultShoot <= shootNext;
            faultSkip  <= skipNext;
            faultDead  <= deadNext;
            faultAny   <= shootNext | skipNext | deadNext;
        end
    end

endmodule

// File: tb/tb_motoro3_gate_monitor.sv
// Directed bench for motoro3_gate_monitor: rotation table plus hand-written fault/timeout/reset sequences.
module tb_motoro3_gate_monitor;

    localparam int          PW   = 20;
    localparam int unsigned TMO  = 2000;
    localparam int          DMIN = 4;

    logic          clk = 1'b0;
    logic          nRst;
    logic          aHP, aLN, bHP, bLN, cHP, cLN, clrFault;
    logic [2:0]    sector;
    logic          running, dirRev, periodValid;
    logic [PW-1:0] period;
    logic          faultShoot, faultSkip, faultDead, faultAny;

    motoro3_gate_monitor #(.PW(PW), .TIMEOUT(TMO), .DEAD_MIN(DMIN)) dut (
        .clk(clk), .nRst(nRst),
        .aHP(aHP), .aLN(aLN), .bHP(bHP), .bLN(bLN), .cHP(cHP), .cLN(cLN),
        .clrFault(clrFault),
        .sector(sector), .running(running), .dirRev(dirRev),
        .period(period), .periodValid(periodValid),
        .faultShoot(faultShoot), .faultSkip(faultSkip), .faultDead(faultDead), .faultAny(faultAny)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pvCount = 0;

    always @(negedge clk) if (periodValid === 1'b1) pvCount++;

    typedef struct {
        int code;   // 0..5 sector, 6 = all gates off
        int hold;
        int eSec;
        int eRun;
        int eDir;
        int ePv;
        int ePer;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // hp bit i = phase i high gate, ln bit i = phase i low gate (active-low)
    task automatic setRaw(input logic [2:0] hp, input logic [2:0] ln);
        aHP = hp[0]; bHP = hp[1]; cHP = hp[2];
        aLN = ln[0]; bLN = ln[1]; cLN = ln[2];
    endtask

    task automatic setSec(input int s);
        case (s)
            0: setRaw(3'b001, 3'b101);
            1: setRaw(3'b001, 3'b011);
            2: setRaw(3'b010, 3'b011);
            3: setRaw(3'b010, 3'b110);
            4: setRaw(3'b100, 3'b110);
            5: setRaw(3'b100, 3'b101);
            default: setRaw(3'b000, 3'b111);
        endcase
    endtask

    task automatic pulseClr();
        clrFault = 1'b1;
        cyc(1);
        clrFault = 1'b0;
        cyc(2);
    endtask

    initial begin
        tbl[0]  = '{0, 1000, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1000, 1, 1, 0, 0, 0};
        tbl[2]  = '{2, 1000, 2, 1, 0, 0, 0};
        tbl[3]  = '{3, 1000, 3, 1, 0, 0, 0};
        tbl[4]  = '{4, 1000, 4, 1, 0, 0, 0};
        tbl[5]  = '{5, 1000, 5, 1, 0, 0, 0};
        tbl[6]  = '{0, 1000, 0, 1, 0, 1, 6000};
        tbl[7]  = '{6,    5, 0, 0, 0, 1, 6000};
        tbl[8]  = '{0,  500, 0, 0, 0, 1, 6000};
        tbl[9]  = '{5,  500, 5, 1, 1, 1, 6000};
        tbl[10] = '{4,  500, 4, 1, 1, 1, 6000};
        tbl[11] = '{3,  500, 3, 1, 1, 1, 6000};
        tbl[12] = '{2,  500, 2, 1, 1, 1, 6000};
        tbl[13] = '{1,  500, 1, 1, 1, 1, 6000};
        tbl[14] = '{0,  500, 0, 1, 1, 2, 3000};

        nRst = 1'b0;
        clrFault = 1'b0;
        setSec(6);
        cyc(3);
        chk("rst sector", 32'(sector), 0);
        chk("rst running", 32'(running), 0);
        chk("rst dirRev", 32'(dirRev), 0);
        chk("rst period", 32'(period), 0);
        chk("rst periodValid", 32'(periodValid), 0);
        chk("rst faultAny", 32'(faultAny), 0);
        nRst = 1'b1;
        cyc(2);

        for (int i = 0; i < 15; i++) begin
            setSec(tbl[i].code);
            cyc(tbl[i].hold);
            chk($sformatf("row%0d sector", i), 32'(sector), 32'(tbl[i].eSec));
            chk($sformatf("row%0d running", i), 32'(running), 32'(tbl[i].eRun));
            chk($sformatf("row%0d dirRev", i), 32'(dirRev), 32'(tbl[i].eDir));
            chk($sformatf("row%0d pvCount", i), 32'(pvCount), 32'(tbl[i].ePv));
            chk($sformatf("row%0d period", i), 32'(period), 32'(tbl[i].ePer));
        end
        chk("rotation faultAny", 32'(faultAny), 0);

        // shoot-through in sector 2
        setSec(1); cyc(10);
        setSec(2); cyc(10);
        chk("pre-shoot sector", 32'(sector), 2);
        chk("pre-shoot dirRev", 32'(dirRev), 0);
        setRaw(3'b011, 3'b010);
        cyc(1);
        chk("shoot latency", 32'(faultShoot), 0);
        cyc(1);
        chk("shoot set", 32'(faultShoot), 1);
        cyc(1);
        chk("shoot faultAny", 32'(faultAny), 1);
        chk("shoot sector held", 32'(sector), 2);
        chk("shoot running", 32'(running), 1);
        chk("shoot no skip", 32'(faultSkip), 0);
        setSec(2); cyc(6);
        pulseClr();
        chk("shoot cleared", 32'(faultShoot), 0);
        chk("shoot any cleared", 32'(faultAny), 0);
        setRaw(3'b011, 3'b010);
        cyc(3);
        clrFault = 1'b1; cyc(1); clrFault = 1'b0;
        chk("set dominant", 32'(faultShoot), 1);
        setSec(2); cyc(6);
        pulseClr();
        chk("shoot cleared 2", 32'(faultShoot), 0);

        // reversal then skip 1->4
        setSec(1); cyc(10);
        chk("reverse toggle", 32'(dirRev), 1);
        chk("reverse running", 32'(running), 1);
        setSec(4); cyc(4);
        chk("skip fault", 32'(faultSkip), 1);
        chk("skip running", 32'(running), 0);
        chk("skip sector", 32'(sector), 4);
        setSec(5); cyc(4);
        chk("rearm running", 32'(running), 1);
        chk("rearm dirRev", 32'(dirRev), 0);
        pulseClr();
        chk("skip cleared", 32'(faultSkip), 0);

        // invalid pattern: two highs, no low
        setRaw(3'b011, 3'b111); cyc(4);
        chk("invalid skip", 32'(faultSkip), 1);
        chk("invalid running", 32'(running), 1);
        chk("invalid sector", 32'(sector), 5);
        setSec(5); cyc(4);
        pulseClr();

        // one cycle of all-off
        setSec(6); cyc(1);
        setSec(5); cyc(1);
        chk("off idle", 32'(running), 0);
        cyc(3);
        chk("off armed running", 32'(running), 0);
        chk("off armed sector", 32'(sector), 5);
        setSec(0); cyc(4);
        chk("off rerun", 32'(running), 1);

        // timeout in sector 3
        setSec(1); cyc(4);
        setSec(2); cyc(4);
        setSec(3);
        cyc(TMO - 20);
        chk("pre-timeout running", 32'(running), 1);
        cyc(40);
        chk("timeout running", 32'(running), 0);
        chk("timeout sector", 32'(sector), 3);

        // two-cycle input-to-output latency
        setSec(4); cyc(1);
        chk("latency 1", 32'(sector), 3);
        cyc(1);
        chk("latency 2", 32'(sector), 4);
        chk("latency running", 32'(running), 1);

        // reset mid-rotation with a fault latched
        setSec(5); cyc(5);
        setRaw(3'b011, 3'b111); cyc(3);
        setSec(5); cyc(2);
        nRst = 1'b0; cyc(1);
        chk("midrst running", 32'(running), 0);
        chk("midrst sector", 32'(sector), 0);
        chk("midrst period", 32'(period), 0);
        chk("midrst faultAny", 32'(faultAny), 0);
        chk("midrst faultSkip", 32'(faultSkip), 0);
        cyc(2);
        nRst = 1'b1; cyc(3);
        chk("postrst armed", 32'(running), 0);
        setSec(0); cyc(4);
        chk("postrst run", 32'(running), 1);

`ifdef MON_DEADTIME_CHECK_EN
        setSec(6); cyc(10);
        pulseClr();
        setRaw(3'b001, 3'b111); cyc(5);
        setSec(6); cyc(2);
        setRaw(3'b000, 3'b110); cyc(3);
        chk("dead short gap", 32'(faultDead), 1);
        setSec(6); cyc(10);
        pulseClr();
        chk("dead cleared", 32'(faultDead), 0);
        setRaw(3'b001, 3'b111); cyc(5);
        setSec(6); cyc(4);
        setRaw(3'b000, 3'b110); cyc(3);
        chk("dead legal gap", 32'(faultDead), 0);
`else
        chk("dead tied off", 32'(faultDead), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motoro3_gate_monitor.md
Name: motoro3_gate_monitor

Overview:
- Receive-side checker for the six-line 3-phase gate-drive bus (aHP/aLN/bHP/bLN/cHP/cLN).
- Decodes the six-step commutation sector, rotation direction and electrical period from the driven gate pattern.
- Latches shoot-through, sector-skip and dead-time faults.
- Sits beside the motor driver in the top level and on the bench. Gives the controller closed-loop status and gives verification a self-checking monitor of the drive outputs.

Parameters:
- PW, 20, width of the period counter/output in clk cycles.
- TIMEOUT, 20'd1000000, cycles without a sector change before falling back to IDLE.
- DEAD_MIN, 4, minimum clk cycles both switches of one phase must be off between transitions (used only with the optional feature).

Ports:
- clk  input  1  system clock, 10 MHz
- nRst  input  1  reset, asynchronous, active-low
- aHP  input  1  phase A high-side gate, active-high
- aLN  input  1  phase A low-side gate, active-low (0 = low switch on)
- bHP  input  1  phase B high-side gate, active-high
- bLN  input  1  phase B low-side gate, active-low
- cHP  input  1  phase C high-side gate, active-high
- cLN  input  1  phase C low-side gate, active-low
- clrFault  input  1  synchronous pulse; clears all latched faults
- sector  output  3  last valid sector, 0..5
- running  output  1  state == RUN
- dirRev  output  1  1 = reverse rotation (sector decrementing)
- period  output  PW  clk cycles between consecutive entries into sector 0
- periodValid  output  1  one-cycle pulse when period updates
- faultShoot  output  1  latched: H and L of one phase on together
- faultSkip  output  1  latched: illegal sector transition or illegal pattern
- faultDead  output  1  latched: dead-time violation (0 when feature absent)
- faultAny  output  1  OR of all fault latches, registered

Behaviour:
- Inputs registered once on clk. All decode uses the registered copies; outputs are 1 cycle later (2-cycle input-to-output latency).
- Normalise each phase: hOn = xHP, lOn = ~xLN.
- Pattern decode (one phase H on, one phase L on, third phase fully off):
  - sector 0 = A-H/B-L, 1 = A-H/C-L, 2 = B-H/C-L, 3 = B-H/A-L, 4 = C-H/A-L, 5 = C-H/B-L.
  - All six switches off = OFF pattern.
  - Any other pattern = INVALID.
- Shoot-through: hOn & lOn on any phase sets faultShoot in the same cycle as detection. This has priority over pattern decode; the pattern is treated as INVALID and sector is held.
- State machine (IDLE, ARMED, RUN):
  - IDLE: first valid sector -> ARMED; store sector.
  - ARMED: sector equal -> stay. sector+1 mod 6 -> RUN, dirRev=0. sector-1 mod 6 -> RUN, dirRev=1. Other -> faultSkip, stay ARMED with the new sector stored.
  - RUN: step in the current direction -> stay. Step in the opposite direction -> dirRev toggles, stay RUN (no fault). Jump of 2 or 3 -> faultSkip, go to ARMED.
  - Any state: OFF pattern held 1 cycle -> IDLE. INVALID pattern (not shoot-through) -> faultSkip, state held.
  - Wrap-around 5->0 is +1; 0->5 is -1.
- Timeout counter clears on every sector change. Reaching TIMEOUT -> IDLE.
- Period:
  - The counter runs in ARMED/RUN and saturates at all-ones.
  - On each entry into sector 0 while in RUN: period <= counter+1, periodValid=1 for 1 cycle, counter <= 0.
  - The first sector-0 entry after IDLE only restarts the counter and does not pulse periodValid.
- Fault latches: set-dominant over clrFault in the same cycle. Cleared only by clrFault or reset.
- Reset values: sector=0, running=0, dirRev=0, period=0, periodValid=0, all faults=0, state=IDLE, counters=0.
- Reset asserted mid-rotation: immediate return to reset values. After release, the block needs a fresh valid sector before it arms.

Optional Feature:
- MON_DEADTIME_CHECK_EN defined:
  - Per phase, a small counter tracks cycles with both switches off since the last switch turned off.
  - Turning either switch of that phase on after fewer than DEAD_MIN off cycles, where the previous on-switch was the opposite side, sets faultDead.
- MON_DEADTIME_CHECK_EN undefined: no counters are built and faultDead is tied to 0.

Test Plan:
- Reset, then patterns for sectors 0,1,2,3,4,5,0, each held 1000 cycles -> running=1, dirRev=0, sector tracks 2 cycles late, periodValid pulses once with period=6000, no faults.
- Sectors 0,5,4,3,2,1,0, each held 500 cycles -> dirRev=1, period=3000 on the second sector-0 entry.
- aHP=1 and aLN=0 together while in sector 2 -> faultShoot=1 and faultAny=1 next cycle, sector stays 2; clrFault pulse -> faults clear.
- Running forward, sector jumps 1->4 -> faultSkip=1, state ARMED, running=0; then 4->5 -> running=1.
- All gates off for 1 cycle -> running=0, IDLE. Hold sector 3 unchanged for TIMEOUT cycles -> IDLE.
- With MON_DEADTIME_CHECK_EN and DEAD_MIN=4: A-H off, then A-L on after 2 cycles -> faultDead=1. With a 4-cycle gap -> faultDead stays 0.
